// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive / word-load path.
package uart_pkg;

  // Parity selection as encoded on io_parity_mode; the unused code 3 also means no parity.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_mode_t;

  // Receive frame FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Divisors below this are clamped so the start-bit half-period stays meaningful.
  localparam int MIN_CLK_PER_BIT = 4;

  // True when the raw mode field asks for a parity bit.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == EVEN) || (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_rx_word_loader_if.sv
// Word handshake between the UART word loader (master) and the instruction-memory writer (slave).
interface uart_rx_word_loader_if #(
  parameter int WORD_BYTES = 4
);
  logic                    io_word_valid;
  logic [8*WORD_BYTES-1:0] io_word;
  logic                    io_word_ready;

  modport master (output io_word_valid, output io_word, input io_word_ready);
  modport slave  (input io_word_valid, input io_word, output io_word_ready);
endinterface

// File: rtl/uart_rx_frame.sv
// Serial frame receiver: 2-flop synchroniser, bit-timing counter and frame FSM.
// Emits one-cycle pulses for a good byte, a framing error or a parity error.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] clk_per_bit,
  input  logic [1:0]       parity_mode,
  input  logic             two_stop,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);

  logic                 rx_meta, rx_s;
  rx_state_t            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, n_eff;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_q, par_d, par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 bit_end, half_end;

  // Synchroniser, FSM state and bit counters.
  always_ff @(posedge clock) begin
    // NOTE: every clocked assignment uses <= so all flops update together from pre-edge values.
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      par_bad_q  <= 1'b0;
    end else begin
      rx_meta    <= rx_i;
      rx_s       <= rx_meta;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      par_bad_q  <= par_bad_d;
    end
  end

  // Data shift register.
  always_ff @(posedge clock) begin
    // NOTE: no reset here on purpose; the contents are only used after a full frame has shifted in.
    data_q <= data_d;
  end

  // Next-state logic, bit sampling and per-frame result pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + DIV_W'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    par_bad_d  = par_bad_q;
    data_d     = data_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;

    n_eff    = (clk_per_bit < DIV_W'(MIN_CLK_PER_BIT)) ? DIV_W'(MIN_CLK_PER_BIT) : clk_per_bit;
    // >= rather than == so an illegal mid-frame divisor change cannot strand the counter.
    bit_end  = (cnt_q >= n_eff - DIV_W'(1));
    half_end = (cnt_q >= (n_eff >> 1) - DIV_W'(1));

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (half_end) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
            par_d     = 1'b0;
            par_bad_d = 1'b0;
          end else begin
            state_d = IDLE;  // start bit did not hold: treat as a glitch
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[DATA_BITS-1:1]};  // LSB arrives first
          par_d  = par_q ^ rx_s;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d    = parity_enabled(parity_mode) ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_d     = '0;
          // XOR over data+parity must be 0 for even mode and 1 for odd mode.
          par_bad_d = ((par_q ^ rx_s) != (parity_mode == ODD));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d    = BREAK;
            frame_err  = 1'b1;
            parity_err = par_bad_q;
          end else if (two_stop && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d    = IDLE;
            parity_err = par_bad_q;
            byte_valid = !par_bad_q;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_data = 8'(data_q);
  assign busy      = (state_q != IDLE);

endmodule

// File: rtl/uart_rx_word_loader.sv
// UART receiver feeding a little-endian word packer with a single output register,
// valid/ready handshake and sticky framing/parity/overrun flags.
module uart_rx_word_loader
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int WORD_BYTES = 4,
  parameter int DIV_W      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_rx_i,
  input  logic [DIV_W-1:0]          io_CLK_PER_BIT,
  input  logic [1:0]                io_parity_mode,
  input  logic                      io_two_stop,
  input  logic                      io_flush,
  input  logic                      io_err_clr,
  uart_rx_word_loader_if.master     word_if,
  output logic                      io_frame_err,
  output logic                      io_parity_err,
  output logic                      io_overrun,
  output logic                      io_busy
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic                        rx_valid, rx_frame_err, rx_parity_err;
  logic [7:0]                  rx_byte;
  logic [IDX_W-1:0]            byte_idx_q;
  logic [WORD_BYTES-1:0][7:0]  lane_q, assembled;
  logic [8*WORD_BYTES-1:0]     word_q;
  logic                        valid_q, last_lane, word_done, load;

  uart_rx_frame #(
    .DATA_BITS (DATA_BITS),
    .DIV_W     (DIV_W)
  ) u_frame (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (io_rx_i),
    .clk_per_bit (io_CLK_PER_BIT),
    .parity_mode (io_parity_mode),
    .two_stop    (io_two_stop),
    .byte_valid  (rx_valid),
    .byte_data   (rx_byte),
    .frame_err   (rx_frame_err),
    .parity_err  (rx_parity_err),
    .busy        (io_busy)
  );

  // Word assembly: current lanes plus the arriving byte, and whether it completes a word.
  always_comb begin
    assembled             = lane_q;
    assembled[byte_idx_q] = rx_byte;
    last_lane             = (byte_idx_q == IDX_W'(WORD_BYTES - 1));
    word_done             = rx_valid && last_lane;
    load                  = word_done && (!valid_q || word_if.io_word_ready);
  end

  // Partial-word lane buffer.
  always_ff @(posedge clock) begin
    if (rx_valid) lane_q[byte_idx_q] <= rx_byte;
  end

  // Lane pointer: realigns on errors, flush and word completion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      byte_idx_q <= '0;
    end else if (rx_frame_err || rx_parity_err || io_flush || word_done) begin
      byte_idx_q <= '0;
    end else if (rx_valid) begin
      byte_idx_q <= byte_idx_q + IDX_W'(1);
    end
  end

  // Output word register and handshake; a new load takes priority over the drop of valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      word_q  <= assembled;
    end else if (valid_q && word_if.io_word_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      io_frame_err  <= 1'b0;
      io_parity_err <= 1'b0;
      io_overrun    <= 1'b0;
    end else begin
      io_frame_err  <= rx_frame_err | (io_frame_err & ~io_err_clr);
      io_parity_err <= rx_parity_err | (io_parity_err & ~io_err_clr);
      io_overrun    <= (word_done & ~load) | (io_overrun & ~io_err_clr);
    end
  end

  assign word_if.io_word_valid = valid_q;
  assign word_if.io_word       = word_q;

endmodule

// File: doc/uart_rx_word_loader.md
# uart_rx_word_loader

Parametrised UART receiver and word assembler: the next-generation program-load path of the Ibtida core. Samples a serial line at a runtime-programmable baud divisor and supports runtime parity and stop-bit modes. Detects framing, parity and overrun errors. Packs received bytes little-endian into WORD_BYTES-wide words delivered on a valid/ready handshake to the instruction-memory writer.

## Interface
- DATA_BITS, 8: data bits per frame (5..8).
- WORD_BYTES, 4: bytes per output word (1..8).
- DIV_W, 16: width of the clocks-per-bit divisor.
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-low (0 = reset, sampled on the rising edge of clock).
- io_rx_i  in  1  asynchronous serial line, idle high.
- io_CLK_PER_BIT  in  DIV_W  clocks per bit N; held stable while the line is active; values < 4 are treated as 4.
- io_parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
- io_two_stop  in  1  1 = two stop bits checked.
- io_flush  in  1  one-cycle pulse: discard the partial word.
- io_err_clr  in  1  one-cycle pulse: clear the sticky error flags.
- io_word_valid  out  1  io_word is valid.
- io_word  out  8*WORD_BYTES  assembled word; first byte received in bits [7:0].
- io_word_ready  in  1  consumer accepts the word.
- io_frame_err  out  1  sticky: a stop bit was sampled low.
- io_parity_err  out  1  sticky: parity mismatch.
- io_overrun  out  1  sticky: a completed word was dropped.
- io_busy  out  1  frame in progress (state != IDLE).

## Operation
- io_rx_i passes through a 2-flop synchroniser; the FSM sees only the synchronised rx_s.
- FSM states and transitions:
  - IDLE: rx_s == 0 → START with cnt = 0.
  - START: at cnt == floor(N/2) − 1, rx_s == 0 → DATA with cnt = 0 and bit index = 0; otherwise → IDLE (glitch rejection).
  - DATA: sample at cnt == N − 1, LSB first, and reset cnt. After DATA_BITS samples → PARITY if parity is enabled, else → STOP.
  - PARITY: sample one bit. Even mode requires an even count of ones over data plus parity; odd mode requires an odd count.
  - STOP: sample 1 or 2 stop bits, each at cnt == N − 1. A low sample → BREAK.
  - BREAK: wait for rx_s == 1 → IDLE.
- Good frame: the byte, zero-extended to 8 bits, is written to lane byte_idx. byte_idx increments; when it reaches WORD_BYTES it wraps to 0 and the word completes.
- Parity or framing error: the byte is discarded, byte_idx is reset to 0 (word realignment), and the matching sticky flag is set.
- Word completion:
  - Output register empty, or io_word_ready high in the same cycle → load and assert valid.
  - Otherwise → keep the old word, drop the new one, set io_overrun.
- Handshake: the transfer occurs on a cycle where valid && ready. valid drops the next cycle unless a new word loads in that same cycle.
- io_flush resets byte_idx to 0. It does not affect the FSM or a word already valid. If flush coincides with word completion, completion wins and byte_idx ends at 0 either way.
- io_err_clr clears all sticky flags. If a clear coincides with a new error, the new error wins.

## Timing
- Reset (reset == 0 at a clock edge) forces:
  - FSM = IDLE, cnt = 0, byte_idx = 0, and synchroniser flops = 1.
  - io_word_valid = 0, io_word = 0, all error flags = 0, io_busy = 0.
- Reset mid-frame or mid-word discards everything in progress; there is no recovery of partial data.
- Start detection latency: 2 clocks (synchroniser) after the line falls.
- The start bit is verified floor(N/2) clocks after detection.
- Each later bit is sampled every N clocks, so bit k's sample point is near the centre of its bit cell.
- io_word_valid rises 1 clock after the final stop-bit sample of the completing byte.
- io_busy is high from the cycle the FSM leaves IDLE until it returns to IDLE.
- Changing io_CLK_PER_BIT, io_parity_mode or io_two_stop while io_busy is high is illegal; behaviour in that case is undefined but must not deadlock.

## Structure
- Package uart_pkg holds:
  - the parity_mode_t enum (NONE, EVEN, ODD);
  - the FSM state enum rx_state_t (IDLE, START, DATA, PARITY, STOP, BREAK);
  - constant MIN_CLK_PER_BIT = 4.
- Sub-module uart_rx_frame: synchroniser, FSM and bit sampler. Outputs a byte_valid pulse, the byte, and per-frame error pulses.
- The top level holds the word packer, the output register/handshake and the sticky flags.

## Test plan
- Boot stream: N = 217, 8N1, bytes 13 00 00 00 ff 0f 00 00 with io_word_ready = 1 → two words, 0x00000013 then 0x00000FFF, with no error flags set.
- Parity: io_parity_mode = 1, byte 0x07 sent with parity bit 1 → byte accepted. Same byte with parity bit 0 → io_parity_err = 1 and byte_idx = 0; a following 4-byte group assembles correctly.
- Framing: byte 0xA5 with a low stop bit, line held low 3N then released → io_frame_err = 1 and no byte stored. The next byte is received correctly after the line returns high.
- Overrun: io_word_ready = 0, send 8 bytes 01..08 → io_word = 0x04030201 held and io_overrun = 1. Raise ready → 0x04030201 transferred and valid drops.
- Glitch/min divisor: a 1-clock low pulse on io_rx_i with N = 16 → FSM returns to IDLE and nothing is received. Then N = 2 with byte 0x5A sent at 4 clocks/bit → 0x5A received.
- Reset/flush mid-frame: after 2 bytes, pulse io_flush, then send 4 bytes 11 22 33 44 → 0x44332211. Asserting reset during a data bit → all outputs return to 0 and the next full frame is received cleanly.
